// File: rtl/dispenser_pkg.sv
// Shared types and helpers for the dose-schedule timekeeper: field encodings,
// FSM states and the packed H:M:S time value with its wrap-around increments.
package dispenser_pkg;

    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HOUR_MAX = 23;

    localparam logic [1:0] FIELD_SEC  = 2'd0;
    localparam logic [1:0] FIELD_MIN  = 2'd1;
    localparam logic [1:0] FIELD_HOUR = 2'd2;
    localparam logic [1:0] FIELD_NONE = 2'd3;

    typedef enum logic [1:0] {RUN, SET, COMMIT} state_t;

    typedef struct packed {
        logic [4:0] hours;
        logic [5:0] minutes;
        logic [5:0] seconds;
    } hms_t;

    function automatic logic [5:0] wrap6(input logic [5:0] v, input logic [5:0] max);
        return (v == max) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] wrap5(input logic [4:0] v, input logic [4:0] max);
        return (v == max) ? 5'd0 : v + 5'd1;
    endfunction

    // One-second advance with full carry chain; 23:59:59 rolls to 00:00:00.
    function automatic hms_t hms_tick(input hms_t t);
        hms_t r;
        r = t;
        r.seconds = wrap6(t.seconds, 6'(SEC_MAX));
        if (t.seconds == 6'(SEC_MAX)) begin
            r.minutes = wrap6(t.minutes, 6'(MIN_MAX));
            if (t.minutes == 6'(MIN_MAX)) begin
                r.hours = wrap5(t.hours, 5'(HOUR_MAX));
            end
        end
        return r;
    endfunction

    // Single-field bump with independent wrap and no carry.
    function automatic hms_t hms_bump(input hms_t t, input logic [1:0] field);
        hms_t r;
        r = t;
        case (field)
            FIELD_SEC:  r.seconds = wrap6(t.seconds, 6'(SEC_MAX));
            FIELD_MIN:  r.minutes = wrap6(t.minutes, 6'(MIN_MAX));
            FIELD_HOUR: r.hours   = wrap5(t.hours, 5'(HOUR_MAX));
            default:    ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dose_schedule_clock_hms_counter.sv
// H:M:S register with priority load > carry tick > single-field increment.
module hms_counter
    import dispenser_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  hms_t       load_val,
    input  logic       tick,
    input  logic       inc,
    input  logic [1:0] field,
    output hms_t       value
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (tick) begin
            value <= hms_tick(value);
        end else if (inc) begin
            value <= hms_bump(value, field);
        end
    end

endmodule

// File: rtl/dose_schedule_clock.sv
// Time-of-day keeper with set mode and NUM_ALARMS dose alarms; matched alarms are
// queued as pending flags and issued lowest-index first over a valid/ack handshake.
module dose_schedule_clock
    import dispenser_pkg::*;
#(
    parameter int unsigned NUM_ALARMS = 4,
    parameter int unsigned TICK_DIV   = 50000000,
    parameter int unsigned IDX_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  set,
    input  logic [1:0]            sel_field,
    input  logic                  inc,
    input  logic                  alarm_wr,
    input  logic [IDX_W-1:0]      alarm_idx,
    input  logic                  alarm_en_in,
    input  logic [4:0]            alarm_hours,
    input  logic [5:0]            alarm_minutes,
    input  logic [5:0]            alarm_seconds,
    input  logic                  dispense_ack,
    output logic [4:0]            outhours,
    output logic [5:0]            outminutes,
    output logic [5:0]            outseconds,
    output logic                  set_active,
    output logic [NUM_ALARMS-1:0] alarm_pending,
    output logic                  dispense_valid,
    output logic [IDX_W-1:0]      dispense_idx
);

    localparam int unsigned      PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_TERM = PRE_W'(TICK_DIV - 1);

    state_t                state;
    logic [PRE_W-1:0]      pre_cnt;
    logic                  tick;
    hms_t                  live;
    hms_t                  shadow;
    hms_t                  live_post;
    hms_t                  display;
    hms_t                  alarm_wr_val;
    hms_t                  alarm_time [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] alarm_en;
    logic [NUM_ALARMS-1:0] match;
    logic [NUM_ALARMS-1:0] pending_d;
    logic [IDX_W-1:0]      lowest_idx;

    // COMMIT restarts the prescaler, so any tick landing on that edge is dropped.
    assign tick      = (state != COMMIT) && (pre_cnt == PRE_TERM);
    assign live_post = tick ? hms_tick(live) : live;

    assign alarm_wr_val = '{hours: alarm_hours, minutes: alarm_minutes, seconds: alarm_seconds};

    hms_counter u_live (
        .clock    (clock),
        .reset    (reset),
        .load     (state == COMMIT),
        .load_val (shadow),
        .tick     (tick),
        .inc      (1'b0),
        .field    (FIELD_NONE),
        .value    (live)
    );

    hms_counter u_shadow (
        .clock    (clock),
        .reset    (reset),
        .load     ((state == RUN) && set),
        .load_val (live_post),
        .tick     (1'b0),
        .inc      ((state == SET) && inc),
        .field    (sel_field),
        .value    (shadow)
    );

    assign set_active = (state == SET) || (state == COMMIT);
    assign display    = set_active ? shadow : live;
    assign outhours   = display.hours;
    assign outminutes = display.minutes;
    assign outseconds = display.seconds;

    always_comb begin
        match      = '0;
        pending_d  = alarm_pending;
        lowest_idx = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            match[i] = (state == RUN) && tick && alarm_en[i] && (alarm_time[i] == live_post);
            if (dispense_valid && dispense_ack && (dispense_idx == IDX_W'(i))) begin
                pending_d[i] = 1'b0;
            end
        end
        // A fresh match beats a simultaneous ack of the same slot.
        pending_d = pending_d | match;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (alarm_pending[i]) begin
                lowest_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (set) state <= SET;
                SET:     if (!set) state <= COMMIT;
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pre_cnt <= '0;
        end else if ((state == COMMIT) || (pre_cnt == PRE_TERM)) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                alarm_time[i] <= '0;
            end
            alarm_en       <= '0;
            alarm_pending  <= '0;
            dispense_valid <= 1'b0;
            dispense_idx   <= '0;
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (alarm_wr && (alarm_idx == IDX_W'(i))) begin
                    alarm_time[i] <= alarm_wr_val;
                    alarm_en[i]   <= alarm_en_in;
                end
            end
            alarm_pending <= pending_d;
            if (dispense_valid) begin
                if (dispense_ack) begin
                    dispense_valid <= 1'b0;
                end
            end else if (|alarm_pending) begin
                dispense_valid <= 1'b1;
                dispense_idx   <= lowest_idx;
            end
        end
    end

endmodule

// File: tb/tb_dose_schedule_clock.sv
// Bench for dose_schedule_clock: directed scenarios plus a randomized phase, all
// checked every cycle against a seconds-of-day reference model.
module tb_dose_schedule_clock;

    localparam int unsigned NA = 4;
    localparam int unsigned TD = 4;
    localparam int unsigned IW = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          set = 1'b0;
    logic [1:0]    sel_field = 2'd3;
    logic          inc = 1'b0;
    logic          alarm_wr = 1'b0;
    logic [IW-1:0] alarm_idx = '0;
    logic          alarm_en_in = 1'b0;
    logic [4:0]    alarm_hours = '0;
    logic [5:0]    alarm_minutes = '0;
    logic [5:0]    alarm_seconds = '0;
    logic          dispense_ack = 1'b0;
    logic [4:0]    outhours;
    logic [5:0]    outminutes;
    logic [5:0]    outseconds;
    logic          set_active;
    logic [NA-1:0] alarm_pending;
    logic          dispense_valid;
    logic [IW-1:0] dispense_idx;

    always #5 clock = ~clock;

    dose_schedule_clock #(
        .NUM_ALARMS (NA),
        .TICK_DIV   (TD),
        .IDX_W      (IW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .set            (set),
        .sel_field      (sel_field),
        .inc            (inc),
        .alarm_wr       (alarm_wr),
        .alarm_idx      (alarm_idx),
        .alarm_en_in    (alarm_en_in),
        .alarm_hours    (alarm_hours),
        .alarm_minutes  (alarm_minutes),
        .alarm_seconds  (alarm_seconds),
        .dispense_ack   (dispense_ack),
        .outhours       (outhours),
        .outminutes     (outminutes),
        .outseconds     (outseconds),
        .set_active     (set_active),
        .alarm_pending  (alarm_pending),
        .dispense_valid (dispense_valid),
        .dispense_idx   (dispense_idx)
    );

    int checks = 0;
    int passed = 0;

    // Reference model: times as seconds since midnight; mode 0 run, 1 set, 2 commit.
    int          m_live, m_pcnt, m_mode, m_idx;
    int          m_sh_h, m_sh_m, m_sh_s;
    int          m_at [NA];
    bit          m_en [NA];
    bit [NA-1:0] m_pend;
    bit          m_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic void model_reset();
        m_live = 0; m_pcnt = 0; m_mode = 0; m_idx = 0;
        m_sh_h = 0; m_sh_m = 0; m_sh_s = 0;
        m_pend = '0; m_valid = 1'b0;
        for (int i = 0; i < NA; i++) begin
            m_at[i] = 0;
            m_en[i] = 1'b0;
        end
    endfunction

    function automatic void model_edge();
        bit          tick;
        int          nl;
        bit [NA-1:0] np;
        tick = (m_mode != 2) && (m_pcnt == TD - 1);
        if (m_mode == 2) nl = m_sh_h * 3600 + m_sh_m * 60 + m_sh_s;
        else if (tick) nl = (m_live + 1) % 86400;
        else nl = m_live;
        np = m_pend;
        if (m_valid && dispense_ack) np[m_idx] = 1'b0;
        if (m_mode == 0 && tick) begin
            for (int i = 0; i < NA; i++) if (m_en[i] && m_at[i] == nl) np[i] = 1'b1;
        end
        if (m_valid) begin
            if (dispense_ack) m_valid = 1'b0;
        end else if (m_pend != '0) begin
            m_valid = 1'b1;
            for (int i = NA - 1; i >= 0; i--) if (m_pend[i]) m_idx = i;
        end
        if (m_mode == 0 && set) begin
            m_sh_h = nl / 3600; m_sh_m = (nl / 60) % 60; m_sh_s = nl % 60;
        end else if (m_mode == 1 && inc) begin
            case (sel_field)
                2'd0:    m_sh_s = (m_sh_s + 1) % 60;
                2'd1:    m_sh_m = (m_sh_m + 1) % 60;
                2'd2:    m_sh_h = (m_sh_h + 1) % 24;
                default: ;
            endcase
        end
        if (alarm_wr) begin
            m_at[alarm_idx] = alarm_hours * 3600 + alarm_minutes * 60 + alarm_seconds;
            m_en[alarm_idx] = alarm_en_in;
        end
        m_pcnt = (m_mode == 2) ? 0 : (m_pcnt + 1) % TD;
        case (m_mode)
            0:       if (set) m_mode = 1;
            1:       if (!set) m_mode = 2;
            default: m_mode = 0;
        endcase
        m_live = nl;
        m_pend = np;
    endfunction

    task automatic check_all();
        int d;
        d = (m_mode == 0) ? m_live : m_sh_h * 3600 + m_sh_m * 60 + m_sh_s;
        chk("hours", 32'(outhours), d / 3600);
        chk("minutes", 32'(outminutes), (d / 60) % 60);
        chk("seconds", 32'(outseconds), d % 60);
        chk("set_active", 32'(set_active), 32'(m_mode != 0));
        chk("pending", 32'(alarm_pending), 32'(m_pend));
        chk("valid", 32'(dispense_valid), 32'(m_valid));
        chk("idx", 32'(dispense_idx), m_idx);
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        check_all();
        inc = 1'b0; alarm_wr = 1'b0; dispense_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0; set = 1'b0; inc = 1'b0; alarm_wr = 1'b0; dispense_ack = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("reset_time", 32'({outhours, outminutes, outseconds}), 0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic write_alarm(input int slot, input int h, input int m, input int s, input bit en);
        alarm_idx = IW'(slot); alarm_hours = 5'(h); alarm_minutes = 6'(m);
        alarm_seconds = 6'(s); alarm_en_in = en; alarm_wr = 1'b1;
        step();
    endtask

    task automatic set_time(input int h, input int m, input int s);
        set = 1'b1;
        step();
        sel_field = 2'd2;
        repeat ((h - m_sh_h + 24) % 24) begin inc = 1'b1; step(); end
        sel_field = 2'd1;
        repeat ((m - m_sh_m + 60) % 60) begin inc = 1'b1; step(); end
        sel_field = 2'd0;
        repeat ((s - m_sh_s + 60) % 60) begin inc = 1'b1; step(); end
        sel_field = 2'd3;
        set = 1'b0;
        step();
        step();
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && dispense_valid !== 1'b1; i++) step();
        chk("wait_valid", 32'(dispense_valid), 1);
    endtask

    task automatic serve(input int exp_idx);
        chk("req_idx", 32'(dispense_idx), exp_idx);
        repeat ($urandom_range(0, 3)) step();
        dispense_ack = 1'b1;
        step();
        chk("valid_drop", 32'(dispense_valid), 0);
    endtask

    initial begin
        do_reset();

        repeat (244) step();
        chk("run_244", 32'({outhours, outminutes, outseconds}), 32'({5'd0, 6'd1, 6'd1}));
        repeat (6) step();
        #2;
        do_reset();

        set_time(23, 59, 58);
        chk("preload", 32'({outhours, outminutes, outseconds}), 32'({5'd23, 6'd59, 6'd58}));
        repeat (4) step();
        chk("tick_59", 32'({outhours, outminutes, outseconds}), 32'({5'd23, 6'd59, 6'd59}));
        repeat (4) step();
        chk("midnight", 32'({outhours, outminutes, outseconds}), 0);

        set_time(10, 20, 30);
        set = 1'b1;
        step();
        chk("shadow_load", 32'({outhours, outminutes, outseconds}), 32'({5'd10, 6'd20, 6'd30}));
        sel_field = 2'd0;
        repeat (30) begin inc = 1'b1; step(); end
        chk("sec_wrap", 32'({outhours, outminutes, outseconds}), 32'({5'd10, 6'd20, 6'd0}));
        sel_field = 2'd2;
        repeat (14) begin inc = 1'b1; step(); end
        chk("hour_wrap", 32'(outhours), 0);
        sel_field = 2'd3;
        set = 1'b0;
        step();
        step();
        chk("commit", 32'({outhours, outminutes, outseconds}), 32'({5'd0, 6'd20, 6'd0}));
        repeat (3) step();
        chk("pre_restart0", 32'(outseconds), 0);
        step();
        chk("pre_restart1", 32'(outseconds), 1);

        do_reset();
        write_alarm(1, 0, 0, 5, 1'b1);
        write_alarm(2, 0, 0, 5, 1'b1);
        for (int i = 0; i < 40 && alarm_pending == '0; i++) step();
        chk("two_match", 32'(alarm_pending), 32'b0110);
        chk("match_time", 32'(outseconds), 5);
        wait_valid(3);
        serve(1);
        wait_valid(2);
        serve(2);
        chk("drained", 32'(alarm_pending), 0);

        write_alarm(0, 1, 0, 0, 1'b1);
        write_alarm(1, 0, 0, 5, 1'b0);
        write_alarm(2, 0, 0, 5, 1'b0);
        set_time(1, 0, 0);
        chk("no_fire_on_set", 32'(alarm_pending), 0);
        write_alarm(3, 1, 0, 4, 1'b0);
        repeat (20) step();
        chk("disabled_slot", 32'(alarm_pending), 0);

        do_reset();
        write_alarm(0, 0, 0, 2, 1'b1);
        wait_valid(40);
        chk("first_req", 32'(dispense_idx), 0);
        write_alarm(0, 0, 0, 4, 1'b1);
        for (int i = 0; i < 40 && !(m_pcnt == TD - 1 && m_live == 3); i++) step();
        chk("align_sec", 32'(outseconds), 3);
        dispense_ack = 1'b1;
        step();
        chk("match_wins", 32'(alarm_pending[0]), 1);
        chk("idle_gap", 32'(dispense_valid), 0);
        step();
        chk("rerequest", 32'(dispense_valid), 1);
        serve(0);
        chk("cleared", 32'(alarm_pending), 0);

        write_alarm(1, 0, 0, 7, 1'b1);
        wait_valid(20);
        #2;
        do_reset();

        for (int i = 0; i < NA; i++) write_alarm(i, 0, 0, $urandom_range(1, 40), 1'($urandom_range(0, 3) != 0));
        for (int c = 0; c < 600; c++) begin
            dispense_ack = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) set = ~set;
            inc = ($urandom_range(0, 9) < 3);
            sel_field = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) begin
                alarm_idx = IW'($urandom_range(0, NA - 1));
                alarm_hours = 5'd0;
                alarm_minutes = 6'($urandom_range(0, 2));
                alarm_seconds = 6'($urandom_range(0, 59));
                alarm_en_in = 1'($urandom_range(0, 1));
                alarm_wr = 1'b1;
            end
            step();
        end
        set = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/dose_schedule_clock.md
Name: dose_schedule_clock

Overview:
- Parametrised successor to the dispenser's time-of-day control: a self-contained HH:MM:SS timekeeper with an integrated set mode and NUM_ALARMS programmable dose alarms.
- Matched alarms are queued and issued one at a time to the dispensing mechanism over a valid/ack handshake.
- Sits between the button/debounce front end and the motor/dispense controller. Also drives the HEX display time bus.

Parameters:
- NUM_ALARMS, 4, number of dose alarm slots (1..16).
- TICK_DIV, 50000000, clock cycles per second; internal prescaler terminal count is TICK_DIV-1 (min 2).
- IDX_W, $clog2(NUM_ALARMS) (min 1), width of the alarm index.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- set  in  1  level; high = set mode requested
- sel_field  in  2  field incremented in set mode: 0 sec, 1 min, 2 hour, 3 none
- inc  in  1  one-cycle pulse; increment selected field
- alarm_wr  in  1  one-cycle pulse; write alarm slot
- alarm_idx  in  IDX_W  slot written
- alarm_en_in  in  1  enable bit written with the slot
- alarm_hours  in  5  alarm hour 0..23
- alarm_minutes  in  6  alarm minute 0..59
- alarm_seconds  in  6  alarm second 0..59
- dispense_ack  in  1  dispense controller accepts request
- outhours  out  5  displayed hour
- outminutes  out  6  displayed minute
- outseconds  out  6  displayed second
- set_active  out  1  high in SET and COMMIT
- alarm_pending  out  NUM_ALARMS  per-slot pending flags
- dispense_valid  out  1  request to dispense
- dispense_idx  out  IDX_W  slot being dispensed

Behaviour:
- Reset (async, reset==0): live time, shadow time, prescaler and all alarm slots go to 0. Alarm enables, pending, dispense_valid and dispense_idx go to 0. FSM goes to RUN. Display outputs read 00:00:00.
- Prescaler counts every cycle in RUN and SET. The tick asserts on the cycle the count equals TICK_DIV-1; the count then wraps to 0.
- On each tick the live time advances: seconds 59->0 carries to minutes, 59->0 carries to hours, 23->0. 23:59:59 becomes 00:00:00.
- FSM state RUN:
  - Display shows live time.
  - set=1 moves to SET. On that same edge the shadow time loads from the live time (if a tick occurs on that edge, it loads the post-tick value).
- FSM state SET:
  - Display shows shadow time.
  - Live time keeps running.
  - inc=1 increments the selected shadow field by 1, with independent wrap (sec/min 59->0, hour 23->0) and no carry. sel_field=3 ignores inc.
  - set=0 moves to COMMIT.
- FSM state COMMIT (exactly 1 cycle):
  - Shadow is copied to live and the prescaler clears to 0.
  - Next state is RUN; display returns to live time on the following cycle.
- inc is ignored in RUN and COMMIT.
- Alarm write: alarm_wr stores the time and enable into slot alarm_idx on the next edge, in any state.
  - An index >= NUM_ALARMS is ignored.
  - Writing a slot does not clear its pending bit.
- Alarm match:
  - Evaluated only on a tick in RUN, against the new (post-increment) live time.
  - Every enabled slot whose H:M:S equals the new time sets its pending bit on that edge.
  - No match on COMMIT, so setting the time past an alarm never fires it.
- Dispense handshake:
  - When dispense_valid=0 and any pending bit is set, the next edge asserts dispense_valid with dispense_idx = lowest pending index.
  - dispense_valid and dispense_idx hold stable until a cycle with dispense_ack=1. On that edge pending[dispense_idx] clears and dispense_valid drops.
  - A new request may issue no earlier than the following edge, giving a minimum 1 idle cycle between requests.
  - dispense_ack while dispense_valid=0 is ignored.
- Simultaneous events:
  - Match and ack on the same slot in the same cycle: pending stays set (the new match wins), producing a second request.
  - Tick on the COMMIT edge is discarded, because COMMIT overrides it.
  - set and reset both active: reset wins.
  - Reset mid-handshake drops dispense_valid asynchronously.

Decomposition:
- Shared package dispenser_pkg holds:
  - Constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - Field-select encodings FIELD_SEC/MIN/HOUR/NONE.
  - FSM state enum RUN/SET/COMMIT.
  - A packed hms_t struct (5+6+6 bits).
- One natural sub-module, hms_counter: holds a time value with a tick-carry increment and a per-field no-carry increment. It is instantiated twice, for live and for shadow.

Test Plan:
- Use TICK_DIV=4 throughout.
- Reset then run 4*61 cycles -> display 00:01:01. Assert reset mid-count -> all outputs 0 immediately.
- Preload 23:59:58 via set/commit, run 8 cycles -> 00:00:00 after the second tick, with no carry glitches.
- Set mode: enter at 10:20:30, sel=0 inc x30 -> shadow sec 00 with minutes still 20. sel=2 inc x14 -> hour 00. Live time advances underneath. Drop set -> COMMIT, live = 00:20:00, prescaler restarted.
- Program slot1=00:00:05 en and slot2=00:00:05 en, run from 0 -> pending=0110 on the 5th tick. Requests issue idx1 then idx2, each held until ack; pending returns to 0000.
- Slot0 enabled at 01:00:00. Set time straight to 01:00:00 -> no pending set. Disabled slot matching the time -> no pending set.
- Match and ack on the same slot in the same cycle -> pending stays 1 and a second dispense_valid follows one idle cycle later.
